// File: rtl/matrix_transpose_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : matrix_transpose_seq                                      |
// | Function : loads eight rows into an external 8x8 store, then drains  |
// |            eight columns (or rows) one vector at a time.             |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module matrix_transpose_seq #(
    parameter int DATA_W    = 32,
    parameter int TRANSPOSE = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [8*DATA_W-1:0] in_data,
    output logic [4:0]          mem_address,
    output logic                mem_rw,
    output logic [8*DATA_W-1:0] mem_wdata,
    input  logic [8*DATA_W-1:0] mem_rdata,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [8*DATA_W-1:0] out_data,
    output logic [2:0]          out_index,
    output logic                out_last,
    output logic                busy
);

    typedef enum logic [1:0] {
        S_LOAD    = 2'd0,
        S_ISSUE   = 2'd1,
        S_CAPTURE = 2'd2,
        S_HOLD    = 2'd3
    } state_t;

    // Column reads live at 8..15 in the store, row reads at 0..7.
    localparam logic [4:0] c_READ_BASE = (TRANSPOSE != 0) ? 5'd8 : 5'd0;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [2:0]          r_rcnt;
    logic [2:0]          w_rcnt_nxt;
    logic [2:0]          r_vcnt;
    logic [2:0]          w_vcnt_nxt;
    logic                r_out_valid;
    logic                w_out_valid_nxt;
    logic [8*DATA_W-1:0] r_out_data;
    logic [8*DATA_W-1:0] w_out_data_nxt;
    logic [2:0]          r_out_index;
    logic [2:0]          w_out_index_nxt;
    logic                r_out_last;
    logic                w_out_last_nxt;
    logic [4:0]          w_read_addr;

    assign w_read_addr = c_READ_BASE | {2'b00, r_vcnt};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_LOAD;
            r_rcnt      <= 3'd0;
            r_vcnt      <= 3'd0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_index <= 3'd0;
            r_out_last  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_rcnt      <= w_rcnt_nxt;
            r_vcnt      <= w_vcnt_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_out_data  <= w_out_data_nxt;
            r_out_index <= w_out_index_nxt;
            r_out_last  <= w_out_last_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_rcnt_nxt      = r_rcnt;
        w_vcnt_nxt      = r_vcnt;
        w_out_valid_nxt = r_out_valid;
        w_out_data_nxt  = r_out_data;
        w_out_index_nxt = r_out_index;
        w_out_last_nxt  = r_out_last;
        mem_rw          = 1'b0;
        mem_address     = 5'd0;

        case (r_state)
            S_LOAD: begin
                // The row is written to the store on the same edge it is accepted.
                if (in_valid) begin
                    mem_rw      = 1'b1;
                    mem_address = {2'b00, r_rcnt};
                    w_rcnt_nxt  = r_rcnt + 3'd1;
                    if (r_rcnt == 3'd7) begin
                        w_vcnt_nxt  = 3'd0;
                        w_state_nxt = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                mem_address = w_read_addr;
                w_state_nxt = S_CAPTURE;
            end
            S_CAPTURE: begin
                // Store read data is valid one edge after the address was issued.
                mem_address     = w_read_addr;
                w_out_data_nxt  = mem_rdata;
                w_out_index_nxt = r_vcnt;
                w_out_last_nxt  = (r_vcnt == 3'd7);
                w_out_valid_nxt = 1'b1;
                w_state_nxt     = S_HOLD;
            end
            S_HOLD: begin
                if (out_ready) begin
                    w_out_valid_nxt = 1'b0;
                    if (r_vcnt == 3'd7) begin
                        w_vcnt_nxt  = 3'd0;
                        w_state_nxt = S_LOAD;
                    end else begin
                        w_vcnt_nxt  = r_vcnt + 3'd1;
                        w_state_nxt = S_ISSUE;
                    end
                end
            end
            default: begin
                w_state_nxt = S_LOAD;
            end
        endcase
    end

    assign mem_wdata = in_data;
    assign in_ready  = (r_state == S_LOAD);
    assign busy      = (r_state != S_LOAD);
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_index = r_out_index;
    assign out_last  = r_out_last;

endmodule
`default_nettype wire

// File: doc/matrix_transpose_seq.md
MATRIX_TRANSPOSE_SEQ -- requirements
Module: matrix_transpose_seq

Interface
- REQ-001: Parameter DATA_W, default 32, width of one matrix element.
- REQ-002: Parameter TRANSPOSE, default 1; 1 = drain by columns (addresses 8..15), 0 = drain by rows (addresses 0..7).
- REQ-003: clk  input  1  single clock; all state updates on rising edge.
- REQ-004: reset  input  1  asynchronous, active-high reset.
- REQ-005: in_valid  input  1  input row available.
- REQ-006: in_ready  output  1  block accepts input row this cycle.
- REQ-007: in_data  input  8*DATA_W  one row; element j at bits [DATA_W*j +: DATA_W].
- REQ-008: mem_address  output  5  row/column select to 8x8 matrix store (0..7 row, 8..15 column).
- REQ-009: mem_rw  output  1  1 = write, 0 = read, to matrix store.
- REQ-010: mem_wdata  output  8*DATA_W  write lanes W0..W7 to matrix store, same packing as in_data.
- REQ-011: mem_rdata  input  8*DATA_W  read lanes R0..R7 from matrix store; valid the cycle after a read edge.
- REQ-012: out_valid  output  1  output vector valid.
- REQ-013: out_ready  input  1  downstream accepts output vector.
- REQ-014: out_data  output  8*DATA_W  drained column (or row), same packing.
- REQ-015: out_index  output  3  index of vector on out_data.
- REQ-016: out_last  output  1  high with out_valid on index 7.
- REQ-017: busy  output  1  high in any state other than LOAD.

Function
- REQ-018: FSM states LOAD, ISSUE, CAPTURE, HOLD; 3-bit row counter rcnt, 3-bit vector counter vcnt.
- REQ-019: in_ready SHALL equal (state == LOAD).
- REQ-020: In LOAD, mem_rw = in_valid, mem_address = {2'b00, rcnt}, mem_wdata = in_data (combinational), so a row is written at the same edge it is accepted.
- REQ-021: Outside an accepted LOAD cycle mem_rw SHALL be 0; mem_wdata is don't-care; no store write occurs.
- REQ-022: Each accepted row increments rcnt; acceptance with rcnt == 7 sets rcnt = 0, vcnt = 0, state ISSUE.
- REQ-023: In ISSUE, mem_rw = 0, mem_address = 8 + vcnt if TRANSPOSE = 1 else vcnt; next state CAPTURE.
- REQ-024: In CAPTURE, mem_address/mem_rw as in ISSUE; at the edge, out_data <= mem_rdata, out_index <= vcnt, out_last <= (vcnt == 7), out_valid <= 1; next state HOLD.
- REQ-025: In LOAD and HOLD with no accepted row, mem_address SHALL be 0 and mem_rw 0.
- REQ-026: In HOLD, out_data, out_index, out_last SHALL stay stable while out_valid && !out_ready.
- REQ-027: In HOLD with out_ready: out_valid <= 0; if vcnt == 7, vcnt = 0, state LOAD; else vcnt++, state ISSUE.
- REQ-028: Latency: out_valid for index 0 rises 2 clock edges after the edge accepting row 7; each next vector 2 edges after prior handshake.
- REQ-029: out_ready while out_valid = 0 SHALL have no effect; in_valid outside LOAD SHALL be ignored.
- REQ-030: in_valid held low mid-load leaves rcnt unchanged; load resumes at next accepted row.
- REQ-031: Store contents SHALL not be relied on across blocks; every block overwrites all 8 rows before draining.

Reset
- REQ-032: reset high SHALL immediately force state LOAD, rcnt 0, vcnt 0, out_valid 0, out_last 0, out_index 0, out_data 0; in_ready = 1, mem_rw = 0, busy = 0.
- REQ-033: reset mid-load or mid-drain SHALL abort the block; partially loaded rows are discarded logically; next accepted row is row 0.

Verification
- REQ-034: TRANSPOSE=1, rows r=0..7 with element (r,c) = 16r+c, in_valid constant, out_ready=1 -> 8 vectors, index k element j = 16j+k, out_last only on index 7, then in_ready = 1.
- REQ-035: TRANSPOSE=0, same data -> vector k element j = 16k+j; mem_address sequence 0..7 during drain.
- REQ-036: out_ready=0 for 5 cycles on index 3 -> out_data/out_index/out_last frozen, mem_rw = 0, no index skipped or repeated.
- REQ-037: in_valid toggled 1/0 each cycle while loading -> exactly 8 writes to addresses 0..7 in order, mem_rw never high when in_valid low; drain output matches REQ-034.
- REQ-038: reset asserted during HOLD of index 4 -> out_valid 0 same cycle, in_ready 1; new full block drains with index 0 first and correct data.
- REQ-039: in_valid held high throughout drain with changing in_data -> no store writes during drain; output unaffected.
